rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single general write port between two writeback requesters, with round-robin arbitration:
- A: ALU writeback.
- B: memory-load writeback.

It registers the winning write, so the register file sees it one cycle after acceptance. It also aligns the COUT write with that pipeline stage, exposes a pending-write mask for hazard checks, and counts arbitration conflicts.

Parameters:
- COUNT, 3, register-address width of the file; the general write port addresses COUNT-1 bits (registers 0..2**(COUNT-1)-1).
- DW, 8, data width.
- CW, 8, conflict-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  stalls all grants while high.
- a_valid  in  1  requester A has a write.
- a_addr  in  COUNT-1  A destination register.
- a_data  in  DW  A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  requester B has a write.
- b_addr  in  COUNT-1  B destination register.
- b_data  in  DW  B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- cout_req  in  1  COUT update request.
- cout_in  in  DW  COUT value.
- write_enable  out  1  to register file write_enable.
- write_addr  out  COUNT-1  to register file rs.
- write_data  out  DW  to register file write_data.
- cout_write_enable  out  1  to register file cout_write_enable.
- cout_data  out  DW  to register file cout_data.
- pending_mask  out  2**(COUNT-1)  one-hot of write_addr when write_enable=1, else 0.
- last_grant  out  1  0 = A won last contested/uncontested grant, 1 = B.
- conflict_cnt  out  CW  saturating count of contested cycles.

Behaviour:
- Reset (reset=1 at an edge):
  - write_enable=0, write_addr=0, write_data=0.
  - cout_write_enable=0, cout_data=0, conflict_cnt=0.
  - last_grant=1, so A wins the first contention.
  - Reset overrides every other input that cycle.
- Arbitration, combinational, every cycle with hold=0:
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: the requester not equal to last_grant wins (last_grant=1 gives A; last_grant=0 gives B). The loser's ready=0.
  - Neither valid: both ready=0.
  - At most one ready high per cycle.
- hold=1:
  - a_ready=b_ready=0.
  - No grant; next write_enable=0; last_grant and conflict_cnt unchanged.
  - cout path is not affected by hold.
- Acceptance is valid & ready. A requester must keep valid, addr and data stable until ready. Dropping valid without ready is permitted; nothing is written.
- Output stage, at each edge:
  - If a grant occurred: write_enable<=1; write_addr/write_data <= winner's addr/data; last_grant <= winner (0=A, 1=B).
  - Otherwise write_enable<=0; write_addr/write_data hold their previous values.
  - Latency is exactly 1 cycle from acceptance to write_enable. Throughput is one write per cycle.
- COUT path: cout_write_enable<=cout_req and cout_data<=cout_in when cout_req=1, independent of arbitration.
  - A COUT write and a general write in the same cycle are both issued. They never collide, because the general port cannot address register 2**COUNT-1.
- pending_mask: combinational from the output stage; bit write_addr set only while write_enable=1.
- conflict_cnt: increments by 1 on each cycle with a_valid=b_valid=1 and hold=0. It saturates at 2**CW-1 with no wrap.
- Same-address contention (a_addr==b_addr): resolved purely by round-robin. The two writes land on consecutive cycles; the later grant's data persists.
- A requester that keeps losing wins within 2 cycles, because round-robin guarantees alternation under continuous contention.
- Reset asserted mid-stream: any registered write is dropped (write_enable=0 next cycle) and ready is forced low that cycle.

Test Plan:
- Reset then idle: assert reset 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, all outputs 0, last_grant=1; first post-reset cycle grants A.
- Single writer: A valid, addr=2, data=8'h5A -> a_ready=1 same cycle; next cycle write_enable=1, write_addr=2, write_data=8'h5A, pending_mask=4'b0100; then write_enable=0.
- Continuous contention for 4 cycles:
  - A(addr 1, 8'h11) and B(addr 3, 8'h33) valid throughout -> grants A,B,A,B; conflict_cnt=4.
  - Each requester advances its data after acceptance.
- Same-address race: A(addr 0, 8'hAA) and B(addr 0, 8'hBB), last_grant=1 -> writes AA then BB on consecutive cycles; final write_data=8'hBB.
- Hold: contention with hold=1 for 3 cycles -> no ready, write_enable=0, conflict_cnt unchanged, last_grant unchanged. cout_req=1, cout_in=8'h01 during hold -> next cycle cout_write_enable=1, cout_data=8'h01.
- Saturation and mid-reset:
  - With CW=8, after 300 contested cycles conflict_cnt=8'hFF.
  - Reset asserted with write_enable=1 -> next cycle write_enable=0, conflict_cnt=0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Writeback-side bundle for rf_write_arbiter: two write requesters, COUT update,
// and the register-file-facing write stage plus status outputs.
interface rf_write_arbiter_if #(
  parameter int COUNT = 3,
  parameter int DW    = 8,
  parameter int CW    = 8
) ();
  localparam int AW = COUNT - 1;
  localparam int NR = 2 ** AW;

  logic          hold;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          cout_req;
  logic [DW-1:0] cout_in;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          cout_write_enable;
  logic [DW-1:0] cout_data;
  logic [NR-1:0] pending_mask;
  logic          last_grant;
  logic [CW-1:0] conflict_cnt;

  modport slave (
    input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data, cout_req, cout_in,
    output a_ready, b_ready, write_enable, write_addr, write_data,
           cout_write_enable, cout_data, pending_mask, last_grant, conflict_cnt
  );

  modport master (
    output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data, cout_req, cout_in,
    input  a_ready, b_ready, write_enable, write_addr, write_data,
           cout_write_enable, cout_data, pending_mask, last_grant, conflict_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's general write port between
// ALU (A) and load (B) writeback, with a registered write stage and COUT alignment.
module rf_write_arbiter #(
  parameter int COUNT = 3,
  parameter int DW    = 8,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);
  localparam int AW = COUNT - 1;
  localparam int NR = 2 ** AW;

  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          cwe_q, cwe_d;
  logic [DW-1:0] cdata_q, cdata_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] conflict_q, conflict_d;

  logic          open;
  logic          a_gnt, b_gnt, contend;
  logic [NR-1:0] mask;

  // Grants are withheld during reset so nothing is accepted that would be dropped.
  always_comb begin
    open    = ~reset & ~bus.hold;
    a_gnt   = open & bus.a_valid & (~bus.b_valid | last_grant_q);
    b_gnt   = open & bus.b_valid & (~bus.a_valid | ~last_grant_q);
    contend = open & bus.a_valid & bus.b_valid;
  end

  always_comb begin
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    conflict_d   = conflict_q;
    cwe_d        = bus.cout_req;
    cdata_d      = cdata_q;
    if (a_gnt) begin
      we_d         = 1'b1;
      addr_d       = bus.a_addr;
      data_d       = bus.a_data;
      last_grant_d = 1'b0;
    end else if (b_gnt) begin
      we_d         = 1'b1;
      addr_d       = bus.b_addr;
      data_d       = bus.b_data;
      last_grant_d = 1'b1;
    end
    if (contend && conflict_q != {CW{1'b1}}) conflict_d = conflict_q + CW'(1);
    if (bus.cout_req) cdata_d = bus.cout_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cwe_q        <= 1'b0;
      cdata_q      <= '0;
      last_grant_q <= 1'b1;
      conflict_q   <= '0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cwe_q        <= cwe_d;
      cdata_q      <= cdata_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

  always_comb begin
    mask = '0;
    if (we_q) mask[addr_q] = 1'b1;
  end

  assign bus.a_ready           = a_gnt;
  assign bus.b_ready           = b_gnt;
  assign bus.write_enable      = we_q;
  assign bus.write_addr        = addr_q;
  assign bus.write_data        = data_q;
  assign bus.cout_write_enable = cwe_q;
  assign bus.cout_data         = cdata_q;
  assign bus.pending_mask      = mask;
  assign bus.last_grant        = last_grant_q;
  assign bus.conflict_cnt      = conflict_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a reference arbiter model pushes each expected
// write into a scoreboard queue as it is accepted; the queue is popped at the write stage.
module tb_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.COUNT(3), .DW(8), .CW(8)) bus ();
  rf_write_arbiter #(.COUNT(3), .DW(8), .CW(8)) dut (.clk(clk), .reset(rst), .bus(bus));

  typedef struct packed {logic [1:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  bit   lg_m   = 1'b1;
  int   cc_m   = 0;
  bit   cwe_m  = 1'b0;
  logic [7:0] cd_m = '0;
  logic [1:0] la_m = '0;
  logic [7:0] ld_m = '0;
  bit   acc_a, acc_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: readies checked mid-cycle, write stage checked just after the edge.
  task automatic tick();
    bit ea, eb, we_exp;
    wr_t w;
    @(negedge clk);
    ea = !rst && !bus.hold && bus.a_valid && (!bus.b_valid || lg_m);
    eb = !rst && !bus.hold && bus.b_valid && (!bus.a_valid || !lg_m);
    chk("a_ready", bus.a_ready, ea);
    chk("b_ready", bus.b_ready, eb);
    acc_a = ea;
    acc_b = eb;
    if (rst) begin
      exp_q.delete();
      lg_m = 1'b1; cc_m = 0; cwe_m = 1'b0; cd_m = '0; la_m = '0; ld_m = '0;
    end else begin
      if (ea) begin exp_q.push_back('{bus.a_addr, bus.a_data}); lg_m = 1'b0; end
      if (eb) begin exp_q.push_back('{bus.b_addr, bus.b_data}); lg_m = 1'b1; end
      if (bus.a_valid && bus.b_valid && !bus.hold && cc_m < 255) cc_m++;
      cwe_m = bus.cout_req;
      if (bus.cout_req) cd_m = bus.cout_in;
    end
    @(posedge clk);
    #1;
    we_exp = exp_q.size() > 0;
    if (we_exp) begin
      w = exp_q.pop_front();
      la_m = w.addr;
      ld_m = w.data;
    end
    chk("write_enable", bus.write_enable, we_exp);
    chk("write_addr", bus.write_addr, la_m);
    chk("write_data", bus.write_data, ld_m);
    chk("pending_mask", bus.pending_mask, we_exp ? (32'd1 << la_m) : 32'd0);
    chk("last_grant", bus.last_grant, lg_m);
    chk("conflict_cnt", bus.conflict_cnt, cc_m);
    chk("cout_write_enable", bus.cout_write_enable, cwe_m);
    chk("cout_data", bus.cout_data, cd_m);
  endtask

  initial begin
    string seq;
    rst = 1'b1;
    bus.hold = 1'b0; bus.cout_req = 1'b0; bus.cout_in = '0;
    bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_addr = 2'd3; bus.b_data = 8'h33;
    repeat (2) tick();
    chk("reset_last_grant", bus.last_grant, 1'b1);

    // Continuous contention: expect A,B,A,B and four conflicts.
    rst = 1'b0;
    seq = "";
    repeat (4) begin
      tick();
      seq = {seq, acc_a ? "A" : (acc_b ? "B" : "-")};
      if (acc_a) bus.a_data = bus.a_data + 8'd1;
      if (acc_b) bus.b_data = bus.b_data + 8'd1;
    end
    chk("grant_seq_ABAB", {31'd0, seq == "ABAB"}, 32'd1);
    chk("conflict4", bus.conflict_cnt, 32'd4);

    // Same-address race with last_grant=1: AA then BB.
    bus.a_addr = 2'd0; bus.a_data = 8'hAA;
    bus.b_addr = 2'd0; bus.b_data = 8'hBB;
    repeat (2) begin
      tick();
      if (acc_a) bus.a_valid = 1'b0;
      if (acc_b) bus.b_valid = 1'b0;
    end
    chk("race_final_data", bus.write_data, 32'hBB);
    tick();

    // Single writer.
    bus.a_valid = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'h5A;
    tick();
    bus.a_valid = 1'b0;
    chk("single_mask", bus.pending_mask, 32'b0100);
    tick();
    chk("single_idle_we", bus.write_enable, 32'd0);

    // Hold under contention, with a COUT update riding through it.
    bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h21;
    bus.b_valid = 1'b1; bus.b_addr = 2'd3; bus.b_data = 8'h43;
    bus.hold = 1'b1; bus.cout_req = 1'b1; bus.cout_in = 8'h01;
    tick();
    bus.cout_req = 1'b0;
    chk("hold_cout_data", bus.cout_data, 32'h01);
    repeat (2) tick();
    bus.hold = 1'b0;
    tick();
    chk("post_hold_b_wins", {31'd0, acc_b}, 32'd1);

    // Saturation of the conflict counter.
    repeat (300) tick();
    chk("conflict_sat", bus.conflict_cnt, 32'hFF);

    // Mid-stream reset while a write is registered.
    chk("pre_reset_we", bus.write_enable, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_reset_we", bus.write_enable, 32'd0);
    chk("mid_reset_cc", bus.conflict_cnt, 32'd0);
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
